// File: rtl/soc_system_onchip_memory_pipe_if.sv
// Avalon-MM slave bundle for soc_system_onchip_memory_pipe: request, write payload and read return.
interface soc_system_onchip_memory_pipe_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 13
);
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    modport master (
        output chipselect, read, write, address, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  chipselect, read, write, address, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/soc_system_onchip_memory_pipe.sv
// Single-port on-chip RAM, Avalon-MM slave with pipelined reads and optional zero-fill after reset.
// Define SOC_ONCHIP_MEM_PARITY_EN to store per-lane even parity and expose parity_error.
module soc_system_onchip_memory_pipe #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned ADDR_WIDTH     = 13,
    parameter int unsigned DEPTH          = 8192,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned CLEAR_ON_RESET = 1,
    parameter string       INIT_FILE      = "soc_system_onchip_memory_pipe.hex"
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          reset_req,
    input  logic                          clken,
    soc_system_onchip_memory_pipe_if.slave bus,
    output logic                          busy
`ifdef SOC_ONCHIP_MEM_PARITY_EN
    ,
    output logic                          parity_error
`endif
);
    localparam int unsigned NLANES = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic                  stall_c;
    logic                  in_range_c;
    logic                  wr_acc_c;
    logic                  rd_acc_c;
    logic                  clr_we_c;
    logic [IDX_W-1:0]      addr_idx_c;
    logic                  mem_we_c;
    logic [IDX_W-1:0]      mem_idx_c;
    logic [NLANES-1:0]     mem_be_c;
    logic [DATA_WIDTH-1:0] mem_wd_c;

    logic                  s1_vld_q;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic                  rd_vld;
    logic [DATA_WIDTH-1:0] rd_data;

    (* ram_init_file = INIT_FILE *)
    logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef SOC_ONCHIP_MEM_PARITY_EN
    logic [NLANES-1:0]     par_mem [DEPTH];
    logic [NLANES-1:0]     s1_par_q;
    logic                  s1_chk_q;
    logic [NLANES-1:0]     rd_par;
    logic                  rd_chk;
`endif

    assign stall_c         = ~clken | reset_req;
    assign bus.waitrequest = stall_c | (state_q == ST_CLEAR) | reset;
    assign busy            = (state_q == ST_CLEAR);
    assign in_range_c      = ({1'b0, bus.address} < (ADDR_WIDTH + 1)'(DEPTH));
    assign addr_idx_c      = IDX_W'(bus.address);
    // Read together with write is a write only.
    assign wr_acc_c        = bus.chipselect & bus.write & ~bus.waitrequest;
    assign rd_acc_c        = bus.chipselect & bus.read & ~bus.write & ~bus.waitrequest;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Zero-fill walks every word once, one per unstalled cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we_c = 1'b0;
        if (!stall_c && !reset) begin
            case (state_q)
                ST_CLEAR: begin
                    clr_we_c = 1'b1;
                    if (cnt_q == IDX_W'(DEPTH - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
                ST_RUN:  state_d = ST_RUN;
                default: state_d = ST_RUN;
            endcase
        end
    end

    assign mem_we_c  = clr_we_c | (wr_acc_c & in_range_c);
    assign mem_idx_c = clr_we_c ? cnt_q : addr_idx_c;
    assign mem_be_c  = clr_we_c ? '1 : bus.byteenable;
    assign mem_wd_c  = clr_we_c ? '0 : bus.writedata;

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < NLANES; i++) begin
                if (mem_be_c[i]) begin
                    mem[mem_idx_c][8*i +: 8] <= mem_wd_c[8*i +: 8];
`ifdef SOC_ONCHIP_MEM_PARITY_EN
                    par_mem[mem_idx_c][i] <= ^mem_wd_c[8*i +: 8];
`endif
                end
            end
        end
    end

    // Synchronous RAM read; out-of-range reads return zero and are never parity-checked.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
`ifdef SOC_ONCHIP_MEM_PARITY_EN
            s1_par_q  <= '0;
            s1_chk_q  <= 1'b0;
`endif
        end else if (!stall_c) begin
            s1_vld_q <= rd_acc_c;
            if (rd_acc_c) begin
                s1_data_q <= in_range_c ? mem[addr_idx_c] : '0;
`ifdef SOC_ONCHIP_MEM_PARITY_EN
                s1_par_q  <= in_range_c ? par_mem[addr_idx_c] : '0;
                s1_chk_q  <= in_range_c;
`endif
            end
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1
        assign rd_vld  = s1_vld_q;
        assign rd_data = s1_data_q;
`ifdef SOC_ONCHIP_MEM_PARITY_EN
        assign rd_par  = s1_par_q;
        assign rd_chk  = s1_chk_q;
`endif
    end else begin : g_lat2
        logic                  s2_vld_q;
        logic [DATA_WIDTH-1:0] s2_data_q;
`ifdef SOC_ONCHIP_MEM_PARITY_EN
        logic [NLANES-1:0]     s2_par_q;
        logic                  s2_chk_q;
`endif
        always_ff @(posedge clk) begin
            if (reset) begin
                s2_vld_q  <= 1'b0;
                s2_data_q <= '0;
`ifdef SOC_ONCHIP_MEM_PARITY_EN
                s2_par_q  <= '0;
                s2_chk_q  <= 1'b0;
`endif
            end else if (!stall_c) begin
                s2_vld_q <= s1_vld_q;
                if (s1_vld_q) begin
                    s2_data_q <= s1_data_q;
`ifdef SOC_ONCHIP_MEM_PARITY_EN
                    s2_par_q  <= s1_par_q;
                    s2_chk_q  <= s1_chk_q;
`endif
                end
            end
        end
        assign rd_vld  = s2_vld_q;
        assign rd_data = s2_data_q;
`ifdef SOC_ONCHIP_MEM_PARITY_EN
        assign rd_par  = s2_par_q;
        assign rd_chk  = s2_chk_q;
`endif
    end

    assign bus.readdatavalid = rd_vld;
    assign bus.readdata      = rd_data;

`ifdef SOC_ONCHIP_MEM_PARITY_EN
    logic              perr_q;
    logic [NLANES-1:0] lane_par_c;

    always_comb begin
        lane_par_c = '0;
        for (int i = 0; i < NLANES; i++) begin
            lane_par_c[i] = ^rd_data[8*i +: 8];
        end
    end

    // Flags in the same cycle as the offending return, then sticks until reset.
    assign parity_error = perr_q | (rd_vld & rd_chk & (lane_par_c != rd_par));

    always_ff @(posedge clk) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else if (!stall_c) begin
            perr_q <= parity_error;
        end
    end
`endif

endmodule

// File: doc/soc_system_onchip_memory_pipe.md
Name: soc_system_onchip_memory_pipe

Overview:
- Parametrised single-port on-chip RAM acting as an Avalon-MM slave with pipelined reads.
- Width, depth and read latency are configurable.
- Provides explicit readdatavalid and waitrequest handshakes.
- Optionally zero-fills the array after reset.
- Sits behind the HPS/fabric interconnect in soc_system as the next-generation scratch/buffer memory.

Parameters:
- DATA_WIDTH, 64: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 13: word address width.
- DEPTH, 8192: number of words; DEPTH <= 2^ADDR_WIDTH.
- READ_LATENCY, 1: cycles from read accept to readdatavalid; legal values 1 or 2 (2 adds an output register).
- CLEAR_ON_RESET, 1: 1 = zero-fill every word after reset before accepting traffic.
- INIT_FILE, "soc_system_onchip_memory_pipe.hex": contents at configuration; ignored when CLEAR_ON_RESET=1.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- reset_req  in  1  reset pending; freezes the block while high.
- clken  in  1  clock enable; freezes all state while low.
- chipselect  in  1  slave select.
- read  in  1  read request.
- write  in  1  write request.
- address  in  ADDR_WIDTH  word address.
- byteenable  in  DATA_WIDTH/8  write byte lanes.
- writedata  in  DATA_WIDTH  write data.
- readdata  out  DATA_WIDTH  read data; valid when readdatavalid=1.
- readdatavalid  out  1  one-cycle pulse per accepted read.
- waitrequest  out  1  slave not accepting.
- busy  out  1  zero-fill in progress.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: readdata=0, readdatavalid=0, busy=CLEAR_ON_RESET, read pipeline flushed, FSM enters CLEAR (CLEAR_ON_RESET=1) or RUN (CLEAR_ON_RESET=0).
- While reset is high, waitrequest=1.
- Stall: stall = ~clken | reset_req. waitrequest = stall | (state==CLEAR) | reset, combinational.
- During stall, the FSM, clear counter, read pipeline and outputs hold their values, and no RAM write occurs.
- FSM CLEAR:
  - Counter starts at 0. Each unstalled cycle writes 0 to word[counter], all lanes, then increments.
  - When word DEPTH-1 has been written, go to RUN next cycle and deassert busy.
  - Clear takes exactly DEPTH unstalled cycles.
- FSM RUN: accept = chipselect & (read | write) & ~waitrequest.
- Write accept: for each lane i with byteenable[i]=1, word[address] byte i <= writedata byte i. Other lanes are unchanged.
- Read accept: readdatavalid=1 exactly READ_LATENCY unstalled cycles later, with readdata = word[address].
  - Back-to-back reads every cycle are sustained: 1 read/cycle, in order.
  - readdata holds its last value when readdatavalid=0.
- Read and write asserted together: treated as a write only; no readdatavalid is generated.
- Read accepted the cycle after a write to the same address returns the new data. Partial byteenable merges with the old lanes.
- Out of range (address >= DEPTH, only when DEPTH < 2^ADDR_WIDTH):
  - The write is dropped.
  - The read is still accepted and returns 0 with a normal readdatavalid.
- chipselect=0: read and write are ignored; no side effects.
- Reset asserted mid-clear: counter restarts at 0 and clearing runs for the full DEPTH cycles again.
- Reset asserted with reads in flight: their readdatavalid pulses are discarded, never emitted.
- Memory inference uses a synchronous-read RAM. The READ_LATENCY=2 output register is in fabric and is reset.

Optional Feature:
- Macro: SOC_ONCHIP_MEM_PARITY_EN.
- When defined:
  - One even-parity bit is stored per byte lane and written with the data.
  - CLEAR stores parity 0.
  - Each read recomputes parity. Any lane mismatch sets output port parity_error (1 bit), which is sticky until reset.
  - parity_error asserts in the same cycle as the offending readdatavalid.
  - Out-of-range reads never flag.
- When undefined: no parity storage, and the parity_error port does not exist.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=16, clken=1 -> waitrequest=1 and busy=1 for exactly 16 cycles after reset drops; then both 0. A read of address 5 returns 0x0.
- Write 0x1122334455667788 to addr 3 with byteenable 0xFF, then write 0xAAAAAAAAAAAAAAAA with byteenable 0x0F, then read addr 3 -> readdata=0x11223344AAAAAAAA.
- READ_LATENCY=2, reads of addr 0,1,2 on consecutive cycles -> readdatavalid high on cycles 2,3,4 after the first accept, with data in address order.
- clken=0 for 3 cycles between read accept and the return -> readdatavalid delayed by exactly 3 cycles and waitrequest=1 throughout; reset_req=1 for 3 cycles gives an identical result.
- Reset asserted at clear count 7, then released -> busy stays high for a further full DEPTH cycles. Reset with 2 reads in flight -> zero readdatavalid pulses afterwards.
- With SOC_ONCHIP_MEM_PARITY_EN defined, force a flipped bit in the stored byte 0 of addr 9, then read addr 9 -> parity_error=1 coincident with readdatavalid; it stays 1 on later clean reads until reset.
